// File: rtl/alu_multiword_sequencer.sv
// Multi-word ALU sequencer: issues one single-word ALU op per cycle, LS word first,
// chaining carry/borrow through ADC/SBB, then returns the wide result with flags.
module alu_multiword_sequencer #(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_WORDS = 4,
  localparam int W         = WORD_SIZE * NUM_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [W-1:0]         req_a,
  input  logic [W-1:0]         req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [W-1:0]         resp_result,
  output logic [7:0]           resp_flags,
  output logic                 resp_err,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_mode,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic [7:0]           alu_flags
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state_q;
  logic [W-1:0]         a_q, b_q, res_q, res_d;
  logic [2:0]           op_q;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic                 last_word, op_arith, op_legal;
  logic                 req_ready_q, resp_valid_q, resp_err_q, busy_q;
  logic [W-1:0]         resp_result_q;
  logic [7:0]           resp_flags_q;
  logic [WORD_SIZE-1:0] alu_a_q, alu_b_q;
  logic [3:0]           alu_mode_q;

  // First word uses plain ADD/SUB; later words chain the ALU's carry/borrow.
  function automatic logic [3:0] mode_for(input logic [2:0] op, input logic first);
    case (op)
      3'd0:    return first ? 4'd6 : 4'd7;
      3'd1:    return first ? 4'd8 : 4'd9;
      3'd2:    return 4'd11;
      3'd3:    return 4'd12;
      3'd4:    return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

  assign idx_nxt   = idx_q + 1'b1;
  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign op_arith  = (op_q <= 3'd1);
  assign op_legal  = (op_q <= 3'd4);

  always_comb begin
    res_d = res_q;
    res_d[idx_q*WORD_SIZE +: WORD_SIZE] = alu_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      op_q          <= '0;
      idx_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_mode_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q     <= EXEC;
          a_q         <= req_a;
          b_q         <= req_b;
          op_q        <= req_op;
          idx_q       <= '0;
          res_q       <= '0;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          alu_a_q     <= req_a[WORD_SIZE-1:0];
          alu_b_q     <= req_b[WORD_SIZE-1:0];
          alu_mode_q  <= mode_for(req_op, 1'b1);
        end
        EXEC: begin
          res_q <= res_d;
          if (last_word) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_mode_q   <= '0;
            if (op_legal) begin
              resp_result_q <= res_d;
              resp_flags_q  <= {~|res_d, res_d[W-1],
                                op_arith & alu_flags[5], op_arith & alu_flags[4], 4'b0};
              resp_err_q    <= 1'b0;
            end else begin
              resp_result_q <= '0;
              resp_flags_q  <= '0;
              resp_err_q    <= 1'b1;
            end
          end else begin
            idx_q      <= idx_nxt;
            alu_a_q    <= a_q[idx_nxt*WORD_SIZE +: WORD_SIZE];
            alu_b_q    <= b_q[idx_nxt*WORD_SIZE +: WORD_SIZE];
            alu_mode_q <= mode_for(op_q, 1'b0);
          end
        end
        DONE: if (resp_ready) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_mode    = alu_mode_q;

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Directed bench for alu_multiword_sequencer with an 8-bit ideal ALU model that keeps
// its own carry register for ADC/SBB.
module tb_alu_multiword_sequencer;

  localparam int WS = 8;
  localparam int NW = 4;
  localparam int W  = WS * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a, req_b;
  logic          resp_valid, resp_ready;
  logic [W-1:0]  resp_result;
  logic [7:0]    resp_flags;
  logic          resp_err, busy;
  logic [WS-1:0] alu_a, alu_b, alu_c;
  logic [3:0]    alu_mode;
  logic [7:0]    alu_flags;

  int tests = 0;
  int fails = 0;

  logic       force_fl = 1'b0;
  logic       cin;
  logic [8:0] t;
  logic       cy, ov;

  alu_multiword_sequencer #(.WORD_SIZE(WS), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_err(resp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_c(alu_c), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Ideal ALU: carry/borrow out in flags[5], signed overflow in flags[4].
  always_comb begin
    t  = '0;
    cy = 1'b0;
    ov = 1'b0;
    case (alu_mode)
      4'd6, 4'd7: begin
        t  = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, (alu_mode == 4'd7) & cin};
        cy = t[8];
        ov = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'd8, 4'd9: begin
        t  = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, (alu_mode == 4'd9) & cin};
        cy = t[8];
        ov = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'd11: t = {1'b0, alu_a & alu_b};
      4'd12: t = {1'b0, alu_a | alu_b};
      4'd13: t = {1'b0, alu_a ^ alu_b};
      default: t = '0;
    endcase
    alu_c     = t[7:0];
    alu_flags = {(t[7:0] == 8'h00), t[7], cy, ov, 4'b0} | (force_fl ? 8'h30 : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) cin <= 1'b0;
    else       cin <= alu_flags[5];
  end

  // Stimulus helper: runs one request to completion and reports what was observed.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [7:0] f, output logic e,
                        output logic [15:0] modes, output int lat);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b0;
    modes = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (lat <= NW) modes[(lat-1)*4 +: 4] = alu_mode;
      @(posedge clk); #1;
      lat++;
    end
    r = resp_result; f = resp_flags; e = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: got rdy=%b vld=%b busy=%b err=%b want 1 0 0 0",
               req_ready, resp_valid, busy, resp_err);
    end
    tests++;
    if (resp_result !== '0 || resp_flags !== 8'h00 || alu_mode !== 4'd0 ||
        alu_a !== 8'h00 || alu_b !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got res=%h fl=%h mode=%0d a=%h b=%h want all 0",
               resp_result, resp_flags, alu_mode, alu_a, alu_b);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] r; logic [7:0] f; logic e; logic [15:0] m; int lat;
    run_op(3'd0, 32'h00FF_FFFF, 32'h0000_0001, r, f, e, m, lat);
    tests++;
    if (r !== 32'h0100_0000 || f !== 8'h00 || e !== 1'b0) begin
      fails++; $display("FAIL add_carrychain: got %h/%h/%b want 01000000/00/0", r, f, e);
    end
    tests++;
    if (m !== 16'h7776) begin
      fails++; $display("FAIL add_modes: got %h want 7776", m);
    end
    tests++;
    if (lat !== 5) begin
      fails++; $display("FAIL add_latency: got %0d want 5", lat);
    end
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, r, f, e, m, lat);
    tests++;
    if (r !== 32'h0000_0000 || f !== 8'hA0) begin
      fails++; $display("FAIL add_wrap: got %h/%h want 00000000/a0", r, f);
    end
    run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, r, f, e, m, lat);
    tests++;
    if (r !== 32'h8000_0000 || f !== 8'h50) begin
      fails++; $display("FAIL add_ovf: got %h/%h want 80000000/50", r, f);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] r; logic [7:0] f; logic e; logic [15:0] m; int lat;
    run_op(3'd1, 32'h0000_0000, 32'h0000_0001, r, f, e, m, lat);
    tests++;
    if (r !== 32'hFFFF_FFFF || f !== 8'h60 || e !== 1'b0) begin
      fails++; $display("FAIL sub_borrow: got %h/%h/%b want ffffffff/60/0", r, f, e);
    end
    tests++;
    if (m !== 16'h9998) begin
      fails++; $display("FAIL sub_modes: got %h want 9998", m);
    end
    run_op(3'd1, 32'h1234_5678, 32'h1234_5678, r, f, e, m, lat);
    tests++;
    if (r !== 32'h0000_0000 || f !== 8'h80) begin
      fails++; $display("FAIL sub_zero: got %h/%h want 00000000/80", r, f);
    end
  endtask

  task automatic test_xor();
    logic [W-1:0] r; logic [7:0] f; logic e; logic [15:0] m; int lat;
    force_fl = 1'b1;
    run_op(3'd4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, r, f, e, m, lat);
    force_fl = 1'b0;
    tests++;
    if (r !== 32'h5A5A_5A5A || f !== 8'h00) begin
      fails++; $display("FAIL xor_result: got %h/%h want 5a5a5a5a/00", r, f);
    end
    tests++;
    if (m !== 16'hDDDD) begin
      fails++; $display("FAIL xor_modes: got %h want dddd", m);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; logic [7:0] f; logic e; logic [15:0] m; int lat; int n;
    req_op = 3'd0; req_a = 32'h0000_0001; req_b = 32'h0000_0002; req_valid = 1'b1;
    resp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    // New request waits while the response is stalled.
    req_op = 3'd3; req_a = 32'hF0F0_0000; req_b = 32'h0000_0F0F; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (resp_valid !== 1'b1 || resp_result !== 32'h3 || resp_flags !== 8'h00 ||
          req_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_stall%0d: got vld=%b res=%h fl=%h rdy=%b busy=%b want 1 3 00 0 1",
                 i, resp_valid, resp_result, resp_flags, req_ready, busy);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_release: got vld=%b rdy=%b busy=%b want 0 1 0",
                        resp_valid, req_ready, busy);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || alu_mode !== 4'd12) begin
      fails++; $display("FAIL bp_accept: got busy=%b rdy=%b mode=%0d want 1 0 12",
                        busy, req_ready, alu_mode);
    end
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (resp_result !== 32'hF0F0_0F0F || resp_flags !== 8'h40 || n !== 4) begin
      fails++; $display("FAIL bp_queued: got %h/%h after %0d want f0f00f0f/40 after 4",
                        resp_result, resp_flags, n);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    req_op = 3'd0; req_a = 32'h1111_1111; req_b = 32'h2222_2222; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || alu_mode !== 4'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid: got vld=%b rdy=%b mode=%0d busy=%b want 0 1 0 0",
                        resp_valid, req_ready, alu_mode, busy);
    end
    seen = 0;
    resp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (resp_valid) seen++; end
    resp_ready = 1'b0;
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL reset_noresp: got %0d response cycles want 0", seen);
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] r; logic [7:0] f; logic e; logic [15:0] m; int lat;
    run_op(3'd6, 32'hDEAD_BEEF, 32'h1234_5678, r, f, e, m, lat);
    tests++;
    if (r !== '0 || f !== 8'h00 || e !== 1'b1) begin
      fails++; $display("FAIL illegal_resp: got %h/%h/%b want 00000000/00/1", r, f, e);
    end
    tests++;
    if (m !== 16'h0000 || lat !== 5) begin
      fails++; $display("FAIL illegal_exec: got modes %h lat %0d want 0000 5", m, lat);
    end
    run_op(3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, r, f, e, m, lat);
    tests++;
    if (r !== 32'h0F00_0F00 || f !== 8'h00 || e !== 1'b0 || m !== 16'hBBBB) begin
      fails++; $display("FAIL and_after_illegal: got %h/%h/%b/%h want 0f000f00/00/0/bbbb",
                        r, f, e, m);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_xor();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
